weighted_reduce: RTL and testbench
==================================

# weighted_reduce

Sequential reduction engine. It buffers a short vector of signed samples, then walks it one element per cycle and produces one of three results: a weighted sum Σ a[i]*(i+1), a running maximum, or a running minimum. Max and min also report the index of the winning element. The block sits between a streaming sample source and a consumer, with valid/ready handshakes on both sides.

## Interface
- DATA_W, 16, signed sample width
- DEPTH, 8, maximum vector length (≥1)
- IDX_W, derived = $clog2(DEPTH) (min 1), index width
- ACC_W, derived = DATA_W + 2*$clog2(DEPTH+1), result width, sized so no overflow
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample valid
- in_ready  out  1  block accepts a sample
- in_data  in  DATA_W  signed sample
- in_last  in  1  final sample of the vector
- mode  in  2  0 = weighted sum, 1 = max, 2 = min, 3 = reserved (behaves as 0); sampled on the first beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_result  out  ACC_W  signed result
- out_index  out  IDX_W  winner index (max/min) or L-1 (sum)
- busy  out  1  state ≠ IDLE

## Operation
- The FSM has four states: IDLE, LOAD, COMPUTE, DONE.
- **IDLE:** in_ready=1.
  - On an in handshake: write buffer[0], latch mode, set len=1.
  - If in_last or DEPTH==1, go to COMPUTE; otherwise go to LOAD.
- **LOAD:** in_ready=1.
  - Each handshake writes buffer[len] and increments len.
  - On in_last, or when len reaches DEPTH, go to COMPUTE.
  - When len reaches DEPTH, the vector ends even if in_last is low.
- **COMPUTE:** in_ready=0.
  - The index counter i runs 0..len-1, one element per cycle.
  - Sum mode: acc += sext(a[i])*(i+1).
  - Max mode: at i=0, acc=a[0] and idx=0. Afterwards, update only when a[i] > acc (strict), so ties keep the lowest index.
  - Min mode: the same rule with strict <.
  - After i = len-1, go to DONE.
- **DONE:**
  - out_valid=1; out_result and out_index are held stable until out_ready.
  - On handshake, go to IDLE. in_ready stays 0 during the handshake cycle.
- All arithmetic is signed. Samples are sign-extended to ACC_W before multiply/add. The weight is an unsigned (i+1) zero-extended to $clog2(DEPTH+1)+1 bits.
- in_valid is ignored in COMPUTE and DONE.
- out_ready is ignored outside DONE.
- Reset mid-operation: all state clears immediately and the partial vector is discarded.

## Timing
- **Reset values:**
  - in_ready=1
  - out_valid=0
  - out_result=0
  - out_index=0
  - busy=0
  - the buffer is not reset
- Loading a vector of length L takes L accepting cycles; there are no bubbles while in_valid is held high.
- Latency: out_valid rises L+1 cycles after the clock edge of the last accepted sample (L compute cycles plus 1 registered transition into DONE).
- in_ready=1 in the cycle after the out handshake.
- out_result and out_index are registered and change only on the COMPUTE→DONE edge. They hold their values in IDLE until the next result.

## Structure
- Package weighted_reduce_pkg holds:
  - the mode_e enum (MODE_SUM, MODE_MAX, MODE_MIN, MODE_RSVD)
  - the state_e enum (IDLE, LOAD, COMPUTE, DONE)
  - a function that derives ACC_W from DATA_W and DEPTH
- Sub-module weighted_reduce_step is a purely combinational single-element update. It takes mode, acc, idx, a[i] and i, and returns next acc and next idx. The top level holds the FSM, the buffer, the counters and the output registers.

## Test plan
All scenarios use DATA_W=16, DEPTH=8.
- **Sum:** load 3, 1, 2 with in_last on the third beat → out_result=11, out_index=2, out_valid high 4 cycles after the last handshake.
- **Max with tie:** load -5, 7, 7, -1 in mode 1 → out_result=7, out_index=1.
- **Min, auto-terminate:** load 8 samples 10, 9, …, 3 with in_last never asserted, mode 2 → COMPUTE entered after the 8th beat; out_result=3, out_index=7; in_ready=0 from the next cycle.
- **Extreme sum:** load 8 × -32768 in mode 0 → out_result=-1179648 (24-bit, no overflow), out_index=7.
- **Backpressure:** hold out_ready low for 5 cycles in DONE → out_valid, out_result and out_index are stable, in_ready=0 and in_valid is ignored; after the handshake, in_ready=1 on the next cycle.
- **Reset mid-COMPUTE:** assert rst while i=2 → out_valid=0, busy=0, in_ready=1 without waiting for a clock edge. A fresh vector 4, 4 (sum mode) then returns 12.

Source files
------------

// File: rtl/weighted_reduce_pkg.sv
// Shared types and width helpers for the weighted_reduce engine.
package weighted_reduce_pkg;

   typedef enum logic [1:0] {
      MODE_SUM  = 2'd0,
      MODE_MAX  = 2'd1,
      MODE_MIN  = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      DONE    = 2'd3
   } state_e;

   // Result width large enough that a full vector of extreme samples times
   // the largest weight cannot overflow.
   function automatic int acc_width(input int data_w, input int depth);
      return data_w + 2 * $clog2(depth + 1);
   endfunction

   // Index width, never narrower than one bit.
   function automatic int idx_width(input int depth);
      return ($clog2(depth) < 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/weighted_reduce_step.sv
// Single-element combinational update for sum / max / min reduction.
module weighted_reduce_step
   import weighted_reduce_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int IDX_W  = 3,
   parameter int ACC_W  = 24
) (
   input  mode_e                    mode_i,
   input  logic signed [ACC_W-1:0]  acc_i,
   input  logic        [IDX_W-1:0]  idx_i,
   input  logic signed [DATA_W-1:0] sample_i,
   input  logic        [IDX_W-1:0]  i_i,
   output logic signed [ACC_W-1:0]  acc_o,
   output logic        [IDX_W-1:0]  idx_o
);

   localparam int WT_W = $clog2(DEPTH + 1) + 1;

   logic                    first;
   logic        [WT_W-1:0]  weight;
   logic signed [ACC_W-1:0] sample_ext;
   logic signed [ACC_W-1:0] weight_ext;
   logic signed [ACC_W-1:0] product;
   logic signed [ACC_W-1:0] acc_base;

   // Weighted product and per-mode accumulator / winner-index update.
   always_comb begin
      first      = (i_i == '0);
      weight     = WT_W'(i_i) + WT_W'(1);
      sample_ext = {{(ACC_W-DATA_W){sample_i[DATA_W-1]}}, sample_i};
      weight_ext = {{(ACC_W-WT_W){1'b0}}, weight};
      product    = sample_ext * weight_ext;
      acc_base   = first ? '0 : acc_i;
      acc_o      = acc_i;
      idx_o      = idx_i;
      case (mode_i)
         MODE_MAX: begin
            if (first || (sample_ext > acc_i)) begin
               acc_o = sample_ext;
               idx_o = i_i;
            end
         end
         MODE_MIN: begin
            if (first || (sample_ext < acc_i)) begin
               acc_o = sample_ext;
               idx_o = i_i;
            end
         end
         default: begin
            acc_o = acc_base + product;
            idx_o = i_i;
         end
      endcase
   end

endmodule

// File: rtl/weighted_reduce.sv
// Buffers a signed sample vector, then reduces it one element per cycle.
module weighted_reduce
   import weighted_reduce_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int DEPTH  = 8,
   localparam int IDX_W  = idx_width(DEPTH),
   localparam int ACC_W  = acc_width(DATA_W, DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                    in_last,
   input  logic        [1:0]       mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_result,
   output logic        [IDX_W-1:0] out_index,
   output logic                    busy
);

   localparam int LEN_W = $clog2(DEPTH + 1);

   state_e                  state_q;
   mode_e                   mode_q;
   logic        [LEN_W-1:0] len_q;
   logic        [LEN_W-1:0] i_q;
   logic signed [ACC_W-1:0] acc_q;
   logic        [IDX_W-1:0] idx_q;
   logic signed [ACC_W-1:0] result_q;
   logic        [IDX_W-1:0] index_q;
   logic signed [DATA_W-1:0] buf_q [DEPTH];

   logic signed [ACC_W-1:0] acc_d;
   logic        [IDX_W-1:0] idx_d;
   logic                    in_hs;
   logic        [IDX_W-1:0] wr_addr;
   logic signed [DATA_W-1:0] sample;

   // Handshake, buffer addressing and output decode from the state register.
   always_comb begin
      in_ready   = (state_q == IDLE) || (state_q == LOAD);
      in_hs      = in_valid && in_ready;
      wr_addr    = (state_q == IDLE) ? '0 : IDX_W'(len_q);
      sample     = buf_q[IDX_W'(i_q)];
      out_valid  = (state_q == DONE);
      busy       = (state_q != IDLE);
      out_result = result_q;
      out_index  = index_q;
   end

   weighted_reduce_step #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W),
      .ACC_W  (ACC_W)
   ) u_step (
      .mode_i   (mode_q),
      .acc_i    (acc_q),
      .idx_i    (idx_q),
      .sample_i (sample),
      .i_i      (IDX_W'(i_q)),
      .acc_o    (acc_d),
      .idx_o    (idx_d)
   );

   // Sample storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (in_hs) begin
         buf_q[wr_addr] <= in_data;
      end
   end

   // Control FSM, reduction registers and held result.
   // COMPUTE walks i = 0..len-1 and spends one extra cycle at i == len
   // to publish the final accumulator, giving L+1 cycles to out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mode_q   <= MODE_SUM;
         len_q    <= '0;
         i_q      <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
         index_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  mode_q <= mode_e'(mode);
                  len_q  <= LEN_W'(1);
                  i_q    <= '0;
                  if (in_last || (DEPTH == 1)) begin
                     state_q <= COMPUTE;
                  end else begin
                     state_q <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (in_valid) begin
                  len_q <= len_q + LEN_W'(1);
                  if (in_last || (len_q == LEN_W'(DEPTH - 1))) begin
                     state_q <= COMPUTE;
                  end
               end
            end
            COMPUTE: begin
               if (i_q == len_q) begin
                  result_q <= acc_q;
                  index_q  <= idx_q;
                  state_q  <= DONE;
               end else begin
                  acc_q <= acc_d;
                  idx_q <= idx_d;
                  i_q   <= i_q + LEN_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weighted_reduce.sv
// Scoreboard bench for weighted_reduce: directed vectors, queued expectations.
module tb_weighted_reduce;

   localparam int DATA_W = 16;
   localparam int DEPTH  = 8;
   localparam int IDX_W  = 3;
   localparam int ACC_W  = 24;

   logic                     clk;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     in_last;
   logic        [1:0]        mode;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  out_result;
   logic        [IDX_W-1:0]  out_index;
   logic                     busy;

   weighted_reduce #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_index  (out_index),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint res;
      longint idx;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic expect_result(input longint res, input longint idx);
      exp_t e;
      e.res = res;
      e.idx = idx;
      sb.push_back(e);
   endtask

   // One input beat; returns 1 time unit after the accepting edge.
   task automatic send_beat(input logic [1:0] m, input int d, input bit last);
      int bound;
      bound    = 0;
      in_valid = 1'b1;
      in_data  = 16'(d);
      in_last  = last;
      mode     = m;
      forever begin
         @(negedge clk);
         if (in_ready || bound > 50) break;
         bound++;
      end
      if (!in_ready) timeout_fail("in_handshake");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_vec(input logic [1:0] m, input int vals[$], input bit use_last);
      for (int k = 0; k < vals.size(); k++) begin
         send_beat(m, vals[k], use_last && (k == vals.size() - 1));
      end
   endtask

   task automatic wait_out_valid(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      if (!out_valid) timeout_fail("out_valid_wait");
   endtask

   task automatic wait_idle();
      int cnt;
      cnt = 0;
      while (busy && cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      if (busy) timeout_fail("idle_wait");
   endtask

   // Monitor: compare every accepted result against the oldest expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t e;
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got %0d with empty scoreboard", out_result);
         end else begin
            e = sb.pop_front();
            check("result", longint'(out_result), e.res);
            check("index", longint'(out_index), e.idx);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v[$];
      int cyc;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      mode      = 2'd0;
      out_ready = 1'b1;
      #3;
      check("reset_in_ready", in_ready, 1);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_result", longint'(out_result), 0);
      check("reset_out_index", out_index, 0);
      check("reset_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Weighted sum: 3*1 + 1*2 + 2*3 = 11, latency L+1 = 4
      expect_result(11, 2);
      v = {3, 1, 2};
      send_vec(2'd0, v, 1'b1);
      wait_out_valid(cyc);
      check("sum_latency", cyc, 4);
      wait_idle();

      // Max with tie: first 7 wins
      expect_result(7, 1);
      v = {-5, 7, 7, -1};
      send_vec(2'd1, v, 1'b1);
      wait_idle();

      // Min, auto-terminate at DEPTH
      expect_result(3, 7);
      v = {10, 9, 8, 7, 6, 5, 4, 3};
      send_vec(2'd2, v, 1'b0);
      check("autoterm_in_ready", in_ready, 0);
      check("autoterm_busy", busy, 1);
      wait_idle();

      // Extreme sum: -32768 * 36
      expect_result(-1179648, 7);
      v = {-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
      send_vec(2'd0, v, 1'b1);
      wait_idle();

      // Reserved mode behaves as sum: 2*1 + -3*2 = -4
      expect_result(-4, 1);
      v = {2, -3};
      send_vec(2'd3, v, 1'b1);
      wait_idle();

      // Backpressure: 5*1 + -2*2 = 1
      out_ready = 1'b0;
      expect_result(1, 1);
      v = {5, -2};
      send_vec(2'd0, v, 1'b1);
      wait_out_valid(cyc);
      in_valid = 1'b1;
      in_data  = 16'(99);
      mode     = 2'd1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_result", longint'(out_result), 1);
         check("bp_index", out_index, 1);
         check("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("post_hs_in_ready", in_ready, 1);
      check("post_hs_busy", busy, 0);
      check("post_hs_hold_result", longint'(out_result), 1);

      // Reset in the middle of COMPUTE, then a fresh vector
      v = {1, 2, 3, 4, 5};
      send_vec(2'd0, v, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_out_result", longint'(out_result), 0);
      #1;
      rst = 1'b0;
      expect_result(12, 1);
      v = {4, 4};
      send_vec(2'd0, v, 1'b1);
      wait_idle();

      repeat (2) @(posedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
